// File: rtl/matmul_engine.sv
// NxN unsigned matrix multiply with one time-shared MAC; A/B are written and C is read one element per cycle.
// Latency: start -> done takes N^3+2 cycles. While busy, start and load_en are ignored; C stays readable throughout.
module matmul_engine #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(N),
  parameter bit SAT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic                   load_sel_ab,
  input  logic [$clog2(N*N)-1:0] load_index,
  input  logic [DW-1:0]          in_data,
  input  logic                   start,
  input  logic                   output_en,
  input  logic [$clog2(N*N)-1:0] output_sel,
  output logic [DW-1:0]          out_data,
  output logic                   busy,
  output logic                   done
);
  localparam int NN = N*N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [DW-1:0]   a_mem [NN];
  logic [DW-1:0]   b_mem [NN];
  logic [ACCW-1:0] c_mem [NN];
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   i_cnt, j_cnt, k_cnt;

  logic [IW-1:0]   a_idx, b_idx, c_idx;
  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] acc_next;
  logic [ACCW-1:0] c_sel;
  logic [DW-1:0]   c_fmt;
  logic            last_i, last_j, last_k;
  logic            load_ok, sel_ok;

  assign a_idx    = IW'(int'(i_cnt) * N + int'(k_cnt));
  assign b_idx    = IW'(int'(k_cnt) * N + int'(j_cnt));
  assign c_idx    = IW'(int'(i_cnt) * N + int'(j_cnt));
  assign prod     = a_mem[a_idx] * b_mem[b_idx];
  assign acc_next = acc + ACCW'(prod);

  assign last_i = (i_cnt == CW'(N-1));
  assign last_j = (j_cnt == CW'(N-1));
  assign last_k = (k_cnt == CW'(N-1));

  // Indices are wider than needed whenever N*N is not a power of two
  assign load_ok = ({1'b0, load_index} < (IW+1)'(NN));
  assign sel_ok  = ({1'b0, output_sel} < (IW+1)'(NN));

  assign c_sel = c_mem[output_sel];
  assign c_fmt = (SAT && (|c_sel[ACCW-1:DW])) ? {DW{1'b1}} : c_sel[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      k_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= '0;
      for (int n = 0; n < NN; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
    end else begin
      if (output_en)
        out_data <= sel_ok ? c_fmt : '0;

      case (state)
        S_IDLE: begin
          if (load_en) begin
            done <= 1'b0;
            if (load_ok) begin
              if (load_sel_ab) b_mem[load_index] <= in_data;
              else             a_mem[load_index] <= in_data;
            end
          end
          if (start) begin
            done  <= 1'b0;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          acc   <= '0;
          i_cnt <= '0;
          j_cnt <= '0;
          k_cnt <= '0;
          busy  <= 1'b1;
          state <= S_MAC;
        end
        S_MAC: begin
          // Final product of a dot product goes straight into C; acc restarts for the next element
          if (last_k) begin
            c_mem[c_idx] <= acc_next;
            acc          <= '0;
            k_cnt        <= '0;
            if (last_j) begin
              j_cnt <= '0;
              if (last_i) state <= S_DONE;
              else        i_cnt <= i_cnt + 1'b1;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end else begin
            acc   <= acc_next;
            k_cnt <= k_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
